// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int BIN_W_DEF  = 14;
  localparam int DIGITS_DEF = 4;
  localparam int DIGIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest value representable in `digits` decimal digits (10^digits - 1).
  function automatic int max_val(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

  localparam int MAX_VAL = max_val(DIGITS_DEF);

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  always_comb begin
    if (i_digit >= DIGIT_W'(5)) begin
      o_digit = i_digit + DIGIT_W'(3);
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 iteration per clock, registered
// BCD result that holds between conversions, saturating to all-nines on overflow.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [BIN_W-1:0]          i_binInput,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [DIGIT_W*DIGITS-1:0] o_bcdOutput,
  output logic                      o_overflow
);

  localparam int SCR_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_U = 32'(max_val(DIGITS));
  localparam logic [SCR_W-1:0] NINES = {DIGITS{4'h9}};

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [BIN_W-1:0] bin_q,     bin_d;
  logic [SCR_W-1:0] scr_q,     scr_d;
  logic             ovf_lat_q, ovf_lat_d;
  logic [SCR_W-1:0] bcd_q,     bcd_d;
  logic             ovf_q,     ovf_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic [SCR_W-1:0]       scr_adj;
  logic [SCR_W+BIN_W:0]   shift_vec;
  logic [SCR_W-1:0]       scr_shift;
  logic [BIN_W-1:0]       bin_shift;
  logic                   carry_out;
  logic                   ovf_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .i_digit (scr_q[g*DIGIT_W +: DIGIT_W]),
      .o_digit (scr_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // {scratch, bin} shifted left as one vector; the bit leaving the top digit is
  // carry_out, which can only be set when the input already exceeds MAX_VAL.
  assign shift_vec = {scr_adj, bin_q, 1'b0};
  assign carry_out = shift_vec[SCR_W+BIN_W];
  assign scr_shift = shift_vec[SCR_W+BIN_W-1:BIN_W];
  assign bin_shift = shift_vec[BIN_W-1:0];

  assign ovf_in = 32'(i_binInput) > MAX_U;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    scr_d     = scr_q;
    ovf_lat_d = ovf_lat_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d   = SHIFT;
          bin_d     = i_binInput;
          scr_d     = '0;
          cnt_d     = CNT_W'(BIN_W);
          ovf_lat_d = ovf_in;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        scr_d     = scr_shift;
        bin_d     = bin_shift;
        cnt_d     = cnt_q - CNT_W'(1);
        ovf_lat_d = ovf_lat_q | carry_out;
        busy_d    = 1'b1;
        // Last iteration: load the display registers so they are valid during DONE.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = (ovf_lat_q | carry_out) ? NINES : scr_shift;
          ovf_d   = ovf_lat_q | carry_out;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      scr_q     <= '0;
      ovf_lat_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      scr_q     <= scr_d;
      ovf_lat_q <= ovf_lat_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_bcdOutput = bcd_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: decimal-arithmetic reference model compared
// every cycle, plus directed conversions with literal expected BCD and latency.
module tb_bin_to_bcd_seq;

  localparam int BIN_W   = 14;
  localparam int LATENCY = 15;

  logic              clk;
  logic              i_rst;
  logic              i_start;
  logic [BIN_W-1:0]  i_binInput;
  logic              o_busy;
  logic              o_done;
  logic [15:0]       o_bcdOutput;
  logic              o_overflow;

  int checks;
  int errors;

  bin_to_bcd_seq dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_binInput  (i_binInput),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_bcdOutput (o_bcdOutput),
    .o_overflow  (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by repeated division; anything above 9999 saturates.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    if (x > 9999) return 16'h9999;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model: counts remaining busy cycles and publishes results on completion.
  int          m_cnt;
  int          m_val;
  logic        m_busy;
  logic        m_done;
  logic [15:0] m_bcd;
  logic        m_ovf;
  bit          started;

  initial begin
    m_cnt = 0; m_val = 0; m_busy = 0; m_done = 0; m_bcd = '0; m_ovf = 0; started = 0;
  end

  always @(posedge clk) begin
    m_done = 1'b0;
    if (i_rst) begin
      m_cnt = 0; m_busy = 0; m_bcd = '0; m_ovf = 0;
    end else if (m_cnt == 0) begin
      if (i_start) begin
        m_cnt  = BIN_W;
        m_val  = int'(i_binInput);
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end else if (m_cnt > 1) begin
      m_cnt = m_cnt - 1;
    end else begin
      m_cnt  = 0;
      m_busy = 1'b0;
      m_done = 1'b1;
      m_bcd  = to_bcd(m_val);
      m_ovf  = (m_val > 9999);
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_busy", 32'(o_busy), 32'(m_busy));
      check("model_done", 32'(o_done), 32'(m_done));
      check("model_bcd",  32'(o_bcdOutput), 32'(m_bcd));
      check("model_ovf",  32'(o_overflow), 32'(m_ovf));
      if (o_busy && o_done) check("busy_done_overlap", 32'(1), 32'(0));
    end
  end

  // Presents a value with i_start, lets one edge accept it, returns at the first
  // negedge after acceptance (cycle N+1).
  task automatic start_conv(input int val, input bit hold);
    @(negedge clk);
    i_start    = 1'b1;
    i_binInput = BIN_W'(val);
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      i_start    = 1'b0;
      i_binInput = BIN_W'($urandom_range(0, 16383));
    end
  endtask

  // Called at cycle N+1; waits (bounded) for o_done and checks latency and result.
  task automatic wait_done(input string name, input logic [15:0] exp_bcd, input bit exp_ovf);
    int k;
    k = 1;
    while (!o_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 32'(k), 32'(LATENCY));
    check({name, "_bcd"}, 32'(o_bcdOutput), 32'(exp_bcd));
    check({name, "_ovf"}, 32'(o_overflow), 32'(exp_ovf));
  endtask

  task automatic count_idle_dones(input string name, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (o_done) n++;
    end
    check(name, 32'(n), 32'(0));
  endtask

  int          vec_val [7] = '{0, 1234, 9999, 5, 1000, 10000, 16383};
  logic [15:0] vec_bcd [7] = '{16'h0000, 16'h1234, 16'h9999, 16'h0005, 16'h1000, 16'h9999, 16'h9999};
  bit          vec_ovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    checks = 0;
    errors = 0;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_binInput = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_bcd",  32'(o_bcdOutput), 32'h0);
    check("reset_busy", 32'(o_busy), 32'h0);
    check("reset_done", 32'(o_done), 32'h0);
    check("reset_ovf",  32'(o_overflow), 32'h0);
    i_rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start_conv(vec_val[i], 1'b0);
      check($sformatf("busy_after_accept_%0d", vec_val[i]), 32'(o_busy), 32'h1);
      wait_done($sformatf("conv_%0d", vec_val[i]), vec_bcd[i], vec_ovf[i]);
      @(negedge clk);
      check($sformatf("done_single_%0d", vec_val[i]), 32'(o_done), 32'h0);
    end

    // Restarts during SHIFT are ignored; previous result holds until the new o_done.
    start_conv(1234, 1'b0);
    wait_done("prev_1234", 16'h1234, 1'b0);
    start_conv(42, 1'b0);
    for (int k = 2; k < LATENCY; k++) begin
      @(negedge clk);
      i_start = (k == 3 || k == 10);
      check("hold_prev_bcd", 32'(o_bcdOutput), 32'h1234);
      check("hold_no_done", 32'(o_done), 32'h0);
    end
    @(negedge clk);
    i_start = 1'b0;
    check("ignore_done", 32'(o_done), 32'h1);
    check("ignore_bcd", 32'(o_bcdOutput), 32'h0042);
    count_idle_dones("ignore_no_extra_done", 20);

    // Start held high: back-to-back conversions with a new value captured in DONE.
    start_conv(777, 1'b1);
    wait_done("b2b_777", 16'h0777, 1'b0);
    i_binInput = BIN_W'(8);
    @(posedge clk);
    @(negedge clk);
    wait_done("b2b_8", 16'h0008, 1'b0);
    i_start = 1'b0;
    count_idle_dones("b2b_settle", 20);

    // Reset mid-conversion aborts with no o_done; a fresh start completes normally.
    start_conv(4321, 1'b0);
    repeat (6) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("abort_bcd",  32'(o_bcdOutput), 32'h0);
    check("abort_busy", 32'(o_busy), 32'h0);
    check("abort_done", 32'(o_done), 32'h0);
    count_idle_dones("abort_no_done", 20);
    start_conv(4321, 1'b0);
    wait_done("after_abort_4321", 16'h4321, 1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
